instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Producer side of the decode interface. Holds the PC and fetches one instruction per handshake from instruction memory.
- Latches the instruction into an IR and presents opcode, funct and operand fields to the control decoder until the datapath commits.
- On commit, computes the next PC from the decoder's 2-bit next-PC select: PC+4, branch, jump or jr.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset; first fetch address.
- ADDR_W, 32, PC / instruction-memory address width.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  ADDR_W  fetch address; equals pc.
- imem_ack  in  1  instruction memory has returned data this cycle.
- imem_rdata  in  32  instruction word; valid when imem_ack=1.
- npc_sel  in  2  next-PC select from the decoder: 00 PC+4, 01 branch, 10 jump, 11 jr.
- rs_data  in  32  register-file rs value; the jr/jalr target.
- commit  in  1  datapath has finished the current instruction.
- instr_valid  out  1  IR holds a valid instruction.
- instr  out  32  IR contents.
- opcode  out  6  instr[31:26].
- funct  out  6  instr[5:0].
- pc  out  ADDR_W  address of the instruction in IR.
- pc_plus4  out  ADDR_W  pc+4; the link value for jal/jalr.
- align_err  out  1  one-cycle pulse when a jr target has [1:0]≠00.

Behaviour:
- Reset (async, rstn=0):
  - pc=PC_RESET, instr=0, instr_valid=0, imem_req=0, align_err=0, state=BOOT.
  - This holds even mid-fetch; any outstanding request is abandoned.
- FSM states are BOOT, FETCH and HOLD.
- BOOT:
  - Lasts exactly one cycle after rstn rises, then goes to FETCH.
  - imem_req=0; imem_ack is ignored.
- FETCH:
  - imem_req=1 and imem_addr=pc, both stable until imem_ack.
  - On imem_ack: instr<=imem_rdata, instr_valid<=1, state goes to HOLD on the same edge.
  - Minimum latency is one cycle (ack may arrive in the first FETCH cycle). Wait states are unbounded.
- HOLD:
  - imem_req=0, instr_valid=1; IR, pc and derived fields are stable.
  - On commit:
    - pc<=next_pc, instr_valid<=0, state goes to FETCH.
    - The next fetch request appears the cycle after commit.
- Ignored inputs:
  - commit in BOOT or FETCH.
  - imem_ack in BOOT or HOLD.
- next_pc is combinational from pc, instr, npc_sel and rs_data:
  - 00: pc+4.
  - 01: pc+4 + (sign_extend(instr[15:0]) << 2).
  - 10: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - 11: {rs_data[31:2], 2'b00}. If rs_data[1:0]≠0, align_err pulses high for exactly the commit cycle.
- All adds are modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0 with no flag.
- npc_sel and rs_data are sampled only in the commit cycle; X on them outside that cycle must not affect state.
- Throughput: at best one instruction per 2 cycles (FETCH with immediate ack, then HOLD with immediate commit).
- opcode, funct and pc_plus4 are pure wiring/combinational from the IR and pc; no added latency.

Decomposition:
- Shared package: NPC_PLUS4=2'b00, NPC_BRANCH=2'b01, NPC_JUMP=2'b10, NPC_JR=2'b11, matching the decoder's select encoding.
- Also in the package: FSM state encodings (BOOT, FETCH, HOLD) and the default PC_RESET constant.
- One natural sub-module: npc_calc, the purely combinational next-PC and align_err logic, so it can be checked exhaustively in isolation.

Test Plan:
- Reset then boot: rstn low→high; ack tied 1; rdata=32'h2008_0005 → imem_req rises 1 cycle after the reset release, with imem_addr=0. The next cycle gives instr_valid=1, opcode=6'b001000, pc_plus4=4.
- Sequential plus wait states: at pc=0x10, ack delayed 3 cycles → imem_req and imem_addr=0x10 are held for all wait cycles. Commit with npc_sel=00 → next imem_addr=0x14.
- Branch backward: pc=0x20, instr=32'h1000_FFFE, npc_sel=01, commit → next imem_addr=0x1C.
- Jump and jr:
  - pc=0x3000_0040, instr=32'h0800_0100, npc_sel=10 → imem_addr=0x3000_0400.
  - npc_sel=11, rs_data=0x0000_0087 → imem_addr=0x84 and a single-cycle align_err=1.
- Spurious inputs: commit asserted during FETCH and imem_ack asserted during HOLD → no change to pc, instr or state.
- Reset mid-fetch: rstn dropped during a FETCH wait state → imem_req=0 and pc=PC_RESET immediately (asynchronously). After release, the BOOT cycle ignores a stale ack, then re-fetches from address 0.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared encodings for the instruction fetch unit and its decoder-facing interface.
package instr_fetch_unit_pkg;

  // Next-PC select encoding driven by the control decoder.
  localparam logic [1:0] NPC_PLUS4  = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_JR     = 2'b11;

  // Default first fetch address after reset.
  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    StBoot  = 2'b00,
    StFetch = 2'b01,
    StHold  = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_npc_calc.sv
// Purely combinational next-PC selection and jr target alignment check.
module instr_fetch_unit_npc_calc
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [31:0]       instr,
  input  logic [1:0]        npc_sel,
  input  logic [31:0]       rs_data,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] next_pc,
  output logic              misaligned
);

  localparam logic [ADDR_W-1:0] Four = ADDR_W'(4);

  logic [ADDR_W-1:0] branch_off;
  logic [ADDR_W-1:0] jump_tgt;
  logic [ADDR_W-1:0] jr_tgt;

  // Candidate targets; all adds wrap modulo 2^ADDR_W.
  always_comb begin
    pc_plus4   = pc + Four;
    branch_off = {{(ADDR_W - 18){instr[15]}}, instr[15:0], 2'b00};
    jump_tgt   = {pc_plus4[ADDR_W-1:28], instr[25:0], 2'b00};
    // Low two bits are forced to zero; the misalignment is reported separately.
    jr_tgt     = {rs_data[ADDR_W-1:2], 2'b00};
  end

  // Select the next PC and flag a misaligned jr target.
  always_comb begin
    next_pc    = pc_plus4;
    misaligned = 1'b0;
    case (npc_sel)
      NPC_PLUS4:  next_pc = pc_plus4;
      NPC_BRANCH: next_pc = pc_plus4 + branch_off;
      NPC_JUMP:   next_pc = jump_tgt;
      NPC_JR: begin
        next_pc    = jr_tgt;
        misaligned = (rs_data[1:0] != 2'b00);
      end
      default:    next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds the PC, fetches one word per handshake into the IR,
// and advances the PC when the datapath commits the current instruction.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] PC_RESET = PC_RESET_DEFAULT[ADDR_W-1:0]
) (
  input  logic              clk,
  input  logic              rstn,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic [1:0]        npc_sel,
  input  logic [31:0]       rs_data,
  input  logic              commit,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic [5:0]        funct,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              align_err
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] next_pc;
  logic              misaligned;

  instr_fetch_unit_npc_calc #(
    .ADDR_W (ADDR_W)
  ) u_npc_calc (
    .pc         (pc_q),
    .instr      (instr_q),
    .npc_sel    (npc_sel),
    .rs_data    (rs_data),
    .pc_plus4   (pc_plus4),
    .next_pc    (next_pc),
    .misaligned (misaligned)
  );

  // State, PC and IR registers; reset abandons any outstanding fetch.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StBoot;
      pc_q    <= PC_RESET;
      instr_q <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Next-state and handshake outputs; npc_sel/rs_data only matter on a HOLD commit.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    align_err   = 1'b0;
    unique case (state_q)
      StBoot: state_d = StFetch;
      StFetch: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = StHold;
        end
      end
      StHold: begin
        instr_valid = 1'b1;
        if (commit) begin
          pc_d      = next_pc;
          align_err = misaligned;
          state_d   = StFetch;
        end
      end
      default: state_d = StBoot;
    endcase
  end

  // Decoder-facing fields are plain wiring from the IR and PC.
  always_comb begin
    imem_addr = pc_q;
    pc        = pc_q;
    instr     = instr_q;
    opcode    = instr_q[31:26];
    funct     = instr_q[5:0];
  end

endmodule
